// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution filter sequencer.
package conv_pkg;

    localparam int FILTER_SIZE = 3;
    localparam int DATA_W      = 32;
    localparam int DEF_N_CH    = 32;
    localparam int DEF_TAG_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    // Default-sized coordinate tag; the scheduler passes its own exact-width tag type.
    typedef struct packed {
        logic [DEF_TAG_W-1:0] ch;
        logic [DEF_TAG_W-1:0] row;
        logic [DEF_TAG_W-1:0] col;
    } conv_tag_t;

    // Index width with a floor of one bit so single-entry ranges still get a port.
    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_tag_pipe.sv
// Fixed-depth valid+tag delay line matched to the filter datapath latency.
module conv_tag_pipe
    import conv_pkg::*;
#(
    parameter int  DEPTH = 9,
    parameter type tag_t = conv_tag_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    input  tag_t tag_i,
    output logic valid_o,
    output tag_t tag_o
);

    logic [DEPTH-1:0] valid_q;
    tag_t             tag_q [DEPTH];

    // Shift every cycle; the filter has no stall so neither does its tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            tag_q[0]   <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/conv_filter_sched.sv
// Walks every output position of one feature map for each output channel,
// loading weights per channel and tagging each issued window with its coordinates.
module conv_filter_sched
    import conv_pkg::*;
#(
    parameter int  IMG_W    = 28,
    parameter int  IMG_H    = 28,
    parameter int  N_CH     = DEF_N_CH,
    parameter int  PIPE_LAT = 9,
    localparam int OUT_W    = IMG_W - FILTER_SIZE + 1,
    localparam int OUT_H    = IMG_H - FILTER_SIZE + 1,
    localparam int CW       = min1_clog2(N_CH),
    localparam int RW       = min1_clog2(OUT_H),
    localparam int XW       = min1_clog2(OUT_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] wgt_ch,
    output logic          wgt_load,
    input  logic          win_ready,
    output logic [RW-1:0] win_row,
    output logic [XW-1:0] win_col,
    output logic          win_issue,
    output logic          res_valid,
    output logic [CW-1:0] res_ch,
    output logic [RW-1:0] res_row,
    output logic [XW-1:0] res_col
);

    localparam int IW = min1_clog2(PIPE_LAT + 1);

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [RW-1:0] row;
        logic [XW-1:0] col;
    } sched_tag_t;

    sched_state_t  state_q;
    logic [CW-1:0] ch_q;
    logic [RW-1:0] row_q;
    logic [XW-1:0] col_q;
    logic [IW-1:0] inflight_q;
    logic [IW-1:0] inflight_d;
    logic          last_col_s;
    logic          last_row_s;
    logic          last_ch_s;
    sched_tag_t    issue_tag_s;
    sched_tag_t    res_tag_s;

    assign last_col_s = (col_q == XW'(OUT_W - 1));
    assign last_row_s = (row_q == RW'(OUT_H - 1));
    assign last_ch_s  = (ch_q == CW'(N_CH - 1));
    assign win_issue  = (state_q == ST_RUN) && win_ready;

    // Results still inside the datapath; weights may only change once this is zero.
    always_comb begin
        inflight_d = inflight_q;
        if (win_issue && !res_valid) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!win_issue && res_valid) begin
            inflight_d = inflight_q - IW'(1);
        end else begin
            inflight_d = inflight_q;
        end
    end

    // Sequencer state, position/channel counters and in-flight count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        ch_q    <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                ST_LOAD: state_q <= ST_RUN;
                ST_RUN: begin
                    if (win_ready) begin
                        if (last_col_s) begin
                            col_q <= '0;
                            if (last_row_s) begin
                                row_q   <= '0;
                                state_q <= ST_DRAIN;
                            end else begin
                                row_q <= row_q + RW'(1);
                            end
                        end else begin
                            col_q <= col_q + XW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (inflight_q == '0) begin
                        if (last_ch_s) begin
                            state_q <= ST_DONE;
                        end else begin
                            ch_q    <= ch_q + CW'(1);
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign wgt_load = (state_q == ST_LOAD);
    assign wgt_ch   = ch_q;
    assign win_row  = row_q;
    assign win_col  = col_q;

    assign issue_tag_s = '{ch: ch_q, row: row_q, col: col_q};

    conv_tag_pipe #(
        .DEPTH (PIPE_LAT),
        .tag_t (sched_tag_t)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (win_issue),
        .tag_i   (issue_tag_s),
        .valid_o (res_valid),
        .tag_o   (res_tag_s)
    );

    assign res_ch  = res_tag_s.ch;
    assign res_row = res_tag_s.row;
    assign res_col = res_tag_s.col;

endmodule

// File: tb/tb_conv_filter_sched.sv
// Scoreboard bench: stimulus queues expected loads/issues/results/done, a monitor checks them.
module tb_conv_filter_sched;

    localparam int LAT       = 9;
    localparam int NCH       = 2;
    localparam int OW        = 3;
    localparam int OH        = 2;
    localparam int CH_PERIOD = OW * OH + LAT + 2;

    logic       clk = 1'b0;
    logic       rst_n, start, win_ready;
    logic       busy, done, wgt_load, win_issue, res_valid;
    logic [0:0] wgt_ch, win_row, res_ch, res_row;
    logic [1:0] win_col, res_col;

    logic       s_start;
    logic       s_busy, s_done, s_wgt_load, s_win_issue, s_res_valid;
    logic [0:0] s_wgt_ch, s_win_row, s_win_col, s_res_ch, s_res_row, s_res_col;

    typedef struct {
        int ch;
        int row;
        int col;
        int cyc;
    } ev_t;

    ev_t exp_iss_q[$];
    ev_t lat_q[$];
    ev_t exp_load_q[$];
    int  exp_done_q[$];
    ev_t mon_e;
    int  mon_d;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_res    = 0;
    int n_done   = 0;
    bit mon_en   = 1'b0;
    logic [4:0] s_exp [7];

    conv_filter_sched #(.IMG_W(5), .IMG_H(4), .N_CH(NCH), .PIPE_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .wgt_ch(wgt_ch), .wgt_load(wgt_load), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .win_issue(win_issue),
        .res_valid(res_valid), .res_ch(res_ch), .res_row(res_row), .res_col(res_col)
    );

    conv_filter_sched #(.IMG_W(3), .IMG_H(3), .N_CH(1), .PIPE_LAT(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .wgt_ch(s_wgt_ch), .wgt_load(s_wgt_load), .win_ready(1'b1),
        .win_row(s_win_row), .win_col(s_win_col), .win_issue(s_win_issue),
        .res_valid(s_res_valid), .res_ch(s_res_ch), .res_row(s_res_row), .res_col(s_res_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT event against the queued expectations.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wgt_load) begin
                check("load_expected", longint'(exp_load_q.size() > 0), 1);
                check("load_no_inflight", lat_q.size(), 0);
                if (exp_load_q.size() > 0) begin
                    mon_e = exp_load_q.pop_front();
                    check("load_ch", wgt_ch, mon_e.ch);
                    if (mon_e.cyc >= 0) check("load_cycle", cyc, mon_e.cyc);
                end
            end
            if (win_issue) begin
                check("issue_when_ready", win_ready, 1);
                check("issue_expected", longint'(exp_iss_q.size() > 0), 1);
                if (exp_iss_q.size() > 0) begin
                    mon_e = exp_iss_q.pop_front();
                    check("issue_ch", wgt_ch, mon_e.ch);
                    check("issue_row", win_row, mon_e.row);
                    check("issue_col", win_col, mon_e.col);
                    if (mon_e.cyc >= 0) check("issue_cycle", cyc, mon_e.cyc);
                    lat_q.push_back('{mon_e.ch, mon_e.row, mon_e.col, cyc + LAT});
                end
            end
            if (res_valid) begin
                n_res++;
                check("res_expected", longint'(lat_q.size() > 0), 1);
                if (lat_q.size() > 0) begin
                    mon_e = lat_q.pop_front();
                    check("res_ch", res_ch, mon_e.ch);
                    check("res_row", res_row, mon_e.row);
                    check("res_col", res_col, mon_e.col);
                    check("res_cycle", cyc, mon_e.cyc);
                    check("res_wgt_ch", wgt_ch, mon_e.ch);
                end
            end
            if (done) begin
                n_done++;
                check("done_expected", longint'(exp_done_q.size() > 0), 1);
                check("done_no_inflight", lat_q.size(), 0);
                if (exp_done_q.size() > 0) begin
                    mon_d = exp_done_q.pop_front();
                    if (mon_d >= 0) check("done_cycle", cyc, mon_d);
                end
            end
        end
    end

    task automatic queue_pass(input int t0, input bit exact);
        for (int ch = 0; ch < NCH; ch++) begin
            exp_load_q.push_back('{ch, 0, 0, exact ? t0 + 1 + ch * CH_PERIOD : -1});
            for (int k = 0; k < OW * OH; k++) begin
                exp_iss_q.push_back('{ch, k / OW, k % OW,
                                      exact ? t0 + 2 + ch * CH_PERIOD + k : -1});
            end
        end
        exp_done_q.push_back(exact ? t0 + 1 + NCH * CH_PERIOD : -1);
    endtask

    task automatic run_pass(input bit toggle, input bit poke_start, input bit exact);
        int t0, res0, done0;
        bit seen;
        res0  = n_res;
        done0 = n_done;
        seen  = 1'b0;
        @(posedge clk); #1;
        check("idle_busy_before", busy, 0);
        start     = 1'b1;
        win_ready = 1'b1;
        t0        = cyc;
        queue_pass(t0, exact);
        for (int k = 1; k < 400 && !seen; k++) begin
            @(posedge clk); #1;
            start = (poke_start && k == 5);
            if (toggle) win_ready = ~win_ready;
            if (k == 1) check("busy_after_start", busy, 1);
            if (n_done != done0) seen = 1'b1;
        end
        win_ready = 1'b1;
        check("pass_done_seen", seen, 1);
        repeat (3) @(posedge clk);
        #1;
        check("pass_results", n_res - res0, NCH * OW * OH);
        check("pass_one_done", n_done - done0, 1);
        check("pass_issues_left", exp_iss_q.size(), 0);
        check("pass_inflight_left", lat_q.size(), 0);
        check("idle_busy_after", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_exp[0] = 5'b00000;
        s_exp[1] = 5'b11000;
        s_exp[2] = 5'b10100;
        s_exp[3] = 5'b10010;
        s_exp[4] = 5'b10000;
        s_exp[5] = 5'b10001;
        s_exp[6] = 5'b00000;

        rst_n = 1'b0; start = 1'b0; win_ready = 1'b0; s_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            start     = 1'($urandom);
            win_ready = 1'($urandom);
            s_start   = 1'($urandom);
            @(negedge clk);
            check("reset_outputs", {busy, done, wgt_ch, wgt_load, win_row, win_col, win_issue,
                                    res_valid, res_ch, res_row, res_col}, 0);
            check("reset_small_outputs", {s_busy, s_done, s_wgt_ch, s_wgt_load, s_win_row,
                                          s_win_col, s_win_issue, s_res_valid}, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; win_ready = 1'b1; s_start = 1'b0;
        mon_en = 1'b1;

        run_pass(1'b0, 1'b0, 1'b1);
        run_pass(1'b1, 1'b0, 1'b0);
        run_pass(1'b0, 1'b1, 1'b0);

        // Abort a pass mid-run with a one-cycle reset.
        @(posedge clk); #1;
        start = 1'b1; win_ready = 1'b1;
        queue_pass(cyc, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0; win_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_iss_q.delete(); lat_q.delete(); exp_load_q.delete(); exp_done_q.delete();
        @(negedge clk);
        check("post_reset_zero", {busy, wgt_load, win_issue, res_valid, wgt_ch, win_row, win_col}, 0);
        win_ready = 1'b1;
        repeat (15) @(negedge clk);
        check("post_reset_idle", busy, 0);
        run_pass(1'b0, 1'b0, 1'b1);

        // Minimal geometry: 3x3 image, one channel, single-cycle datapath.
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            s_start = (k == 0);
            @(negedge clk);
            check($sformatf("small_ctl_%0d", k),
                  {s_busy, s_wgt_load, s_win_issue, s_res_valid, s_done}, s_exp[k]);
            if (k == 2) check("small_issue_pos", {s_win_row, s_win_col, s_wgt_ch}, 0);
            if (k == 3) check("small_res_tag", {s_res_ch, s_res_row, s_res_col}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
